pipelined_cla_addsub: RTL and testbench

Parametrised, pipelined carry-lookahead adder/subtractor. Splits a Width-bit operation into Width/BlockWidth lookahead blocks, one block per pipeline stage, with carry-in, add/subtract mode, signed-overflow flag and valid/ready flow control. It is the registered, streaming successor to the combinational `cl_adder`. Arithmetic datapaths use it where Width is too wide for a single-cycle lookahead chain.

---
 rtl/pipelined_cla_addsub.sv | 132 +++++++++++++
 tb/tb_pipelined_cla_addsub.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_cla_addsub.sv
// Pipelined carry-lookahead adder/subtractor: one BlockWidth-bit lookahead block
// per stage, lower result bits skewed forward so the full sum emerges aligned.
module pipelined_cla_addsub #(
  parameter int Width      = 32,
  parameter int BlockWidth = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  input  logic             c_i,
  input  logic             sub_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [Width-1:0] sum_o,
  output logic             c_o,
  output logic             ovf_o
);

  localparam int Stages    = Width / BlockWidth;
  localparam int FwdStages = (Stages > 1) ? Stages - 1 : 1;

  logic             en;
  logic             valid_q [Stages];
  logic [Width-1:0] sum_q   [Stages];
  logic             carry_q [Stages];
  logic [Width-1:0] a_q     [FwdStages];
  logic [Width-1:0] b_q     [FwdStages];
  logic             ovf_q;

  // Every carry is a flat sum of products of g/p terms and the block carry-in.
  function automatic logic [BlockWidth:0] lookahead(input logic [BlockWidth-1:0] g,
                                                    input logic [BlockWidth-1:0] p,
                                                    input logic              cin);
    logic [BlockWidth:0] c;
    logic                term;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < BlockWidth; i++) begin
      term = cin;
      for (int j = 0; j <= i; j++) term &= p[j];
      c[i+1] = term;
      for (int j = 0; j <= i; j++) begin
        term = g[j];
        for (int m = j + 1; m <= i; m++) term &= p[m];
        c[i+1] |= term;
      end
    end
    return c;
  endfunction

  // The whole pipeline advances in lockstep; a stalled output freezes every stage.
  assign en      = !valid_q[Stages-1] | ready_i;
  assign ready_o = en;
  assign valid_o = valid_q[Stages-1];
  assign sum_o   = sum_q[Stages-1];
  assign c_o     = carry_q[Stages-1];
  assign ovf_o   = ovf_q;

  for (genvar k = 0; k < Stages; k++) begin : g_stage
    logic [Width-1:0]      a_in;
    logic [Width-1:0]      b_in;
    logic [Width-1:0]      sum_in;
    logic [Width-1:0]      sum_nxt;
    logic                  cin;
    logic                  v_in;
    logic [BlockWidth-1:0] blk_a;
    logic [BlockWidth-1:0] blk_b;
    logic [BlockWidth:0]   c;

    if (k == 0) begin : g_head
      assign a_in   = a_i;
      assign b_in   = b_i ^ {Width{sub_i}};
      assign cin    = c_i ^ sub_i;
      assign sum_in = '0;
      assign v_in   = valid_i;
    end else begin : g_body
      assign a_in   = a_q[k-1];
      assign b_in   = b_q[k-1];
      assign cin    = carry_q[k-1];
      assign sum_in = sum_q[k-1];
      assign v_in   = valid_q[k-1];
    end

    assign blk_a = a_in[k*BlockWidth +: BlockWidth];
    assign blk_b = b_in[k*BlockWidth +: BlockWidth];
    assign c     = lookahead(blk_a & blk_b, blk_a | blk_b, cin);

    // NOTE: sum_nxt gets a full default before the slice overwrite, so no latch is inferred.
    always_comb begin
      sum_nxt = sum_in;
      sum_nxt[k*BlockWidth +: BlockWidth] = blk_a ^ blk_b ^ c[BlockWidth-1:0];
    end

    // NOTE: data registers are reset too, so outputs read zero after reset, not stale values.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        valid_q[k] <= 1'b0;
        sum_q[k]   <= '0;
        carry_q[k] <= 1'b0;
      end else if (en) begin
        valid_q[k] <= v_in;
        sum_q[k]   <= sum_nxt;
        carry_q[k] <= c[BlockWidth];
      end
    end

    if (k < Stages - 1) begin : g_fwd
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          a_q[k] <= '0;
          b_q[k] <= '0;
        end else if (en) begin
          a_q[k] <= a_in;
          b_q[k] <= b_in;
        end
      end
    end else begin : g_tail
      // Top block: carry into the MSB xor carry out of it gives signed overflow.
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          ovf_q <= 1'b0;
        end else if (en) begin
          ovf_q <= c[BlockWidth-1] ^ c[BlockWidth];
        end
      end
    end
  end

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Scoreboard bench for pipelined_cla_addsub (32-bit, 8-bit blocks, latency 4).
module tb_pipelined_cla_addsub;

  localparam int W   = 32;
  localparam int LAT = 4;

  typedef struct {
    logic [W-1:0] sum;
    logic         c;
    logic         ovf;
    logic         chk_lat;
    int           acc_cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_i = 1'b0;
  logic         valid_i = 1'b0;
  logic         ready_o;
  logic [W-1:0] a_i = '0;
  logic [W-1:0] b_i = '0;
  logic         c_i = 1'b0;
  logic         sub_i = 1'b0;
  logic         valid_o;
  logic         ready_i = 1'b1;
  logic [W-1:0] sum_o;
  logic         c_o;
  logic         ovf_o;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  exp_t q[$];

  pipelined_cla_addsub #(.Width(W), .BlockWidth(8)) dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .a_i     (a_i),
    .b_i     (b_i),
    .c_i     (c_i),
    .sub_i   (sub_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .sum_o   (sum_o),
    .c_o     (c_o),
    .ovf_o   (ovf_o)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [W-1:0] sum, input logic c, input logic ovf);
    exp_t e;
    e.sum = sum; e.c = c; e.ovf = ovf; e.chk_lat = 1'b1; e.acc_cyc = 0;
    return e;
  endfunction

  // Reference: plain 33-bit addition of the conditioned operands.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic c, input logic sub);
    logic [W-1:0] bb;
    logic [W:0]   full;
    bb   = sub ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, c ^ sub};
    return mk(full[W-1:0], full[W], (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]));
  endfunction

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                       input logic sub, input exp_t e);
    int n;
    @(negedge clk);
    a_i = a; b_i = b; c_i = c; sub_i = sub; valid_i = 1'b1;
    #2;
    n = 0;
    while (!ready_o && n < 50) begin
      @(negedge clk); #2; n++;
    end
    if (n >= 50) check("issue_timeout", 1, 0);
    e.acc_cyc = cyc;
    q.push_back(e);
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    valid_i = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 60) begin
      @(negedge clk); n++;
    end
    check("drain", q.size(), 0);
  endtask

  // Monitor: samples just before the active edge; pops only on a real handshake.
  initial begin
    exp_t         e;
    logic         stalled;
    logic [W-1:0] held_sum;
    logic         held_c, held_ovf;
    stalled = 1'b0;
    forever begin
      @(negedge clk); #3;
      if (rst_i) begin
        stalled = 1'b0;
        continue;
      end
      if (stalled) begin
        check("stall_sum", sum_o, held_sum);
        check("stall_c", c_o, held_c);
        check("stall_ovf", ovf_o, held_ovf);
      end
      if (valid_o === 1'b1 && ready_i === 1'b0) begin
        check("stall_ready_o", ready_o, 0);
        held_sum = sum_o; held_c = c_o; held_ovf = ovf_o;
        stalled = 1'b1;
      end else begin
        stalled = 1'b0;
      end
      if (valid_o === 1'b1 && ready_i === 1'b1) begin
        if (q.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          e = q.pop_front();
          check("sum", sum_o, e.sum);
          check("c_o", c_o, e.c);
          check("ovf", ovf_o, e.ovf);
          if (e.chk_lat) check("latency", cyc - e.acc_cyc, LAT);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    logic [W-1:0] ra, rb;

    // Reset for two cycles with valid_i high; the presented op must be dropped.
    @(negedge clk);
    rst_i = 1'b1; valid_i = 1'b1; a_i = 32'h1234_5678; b_i = 32'h0000_0001; ready_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_i = 1'b0; valid_i = 1'b0;
    #1;
    check("rst_valid_o", valid_o, 0);
    check("rst_sum_o", sum_o, 0);
    check("rst_c_o", c_o, 0);
    check("rst_ovf_o", ovf_o, 0);
    check("rst_ready_o", ready_o, 1);
    ready_i = 1'b1;
    idle(8);

    // Directed boundary vectors, back to back.
    issue(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, mk(32'h0000_0000, 1'b1, 1'b0));
    issue(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, mk(32'h8000_0000, 1'b0, 1'b1));
    issue(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, mk(32'hFFFF_FFFE, 1'b0, 1'b0));
    issue(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, mk(32'h7FFF_FFFE, 1'b1, 1'b1));
    idle(1);
    drain();

    // Streaming: 16 back-to-back ops with mixed sub_i and c_i.
    for (int i = 0; i < 16; i++) begin
      ra = $urandom;
      rb = $urandom;
      issue(ra, rb, i[1], i[0], model(ra, rb, i[1], i[0]));
    end
    idle(1);
    drain();

    // Backpressure: four ops in flight, output stalled for three cycles.
    for (int i = 0; i < 4; i++) begin
      ra = 32'h0100_00FF * (i + 1);
      rb = 32'h00FF_FF01 + i;
      e = model(ra, rb, i[0], i[1]);
      e.chk_lat = 1'b0;
      issue(ra, rb, i[0], i[1], e);
    end
    @(negedge clk);
    valid_i = 1'b0; ready_i = 1'b0;
    repeat (3) @(negedge clk);
    ready_i = 1'b1;
    drain();

    // Mid-stream reset with three ops in flight: none of them may appear.
    for (int i = 0; i < 3; i++) begin
      ra = 32'hDEAD_0000 + i;
      issue(ra, 32'h1111_1111, 1'b0, 1'b0, model(ra, 32'h1111_1111, 1'b0, 1'b0));
    end
    @(negedge clk);
    valid_i = 1'b0; rst_i = 1'b1;
    q.delete();
    @(negedge clk);
    rst_i = 1'b0;
    idle(10);
    issue(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, mk(32'h0000_0100, 1'b0, 1'b0));
    idle(1);
    drain();

    check("queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
